// File: rtl/msk_and_ghpcll_pipe.sv
// W-lane, 2-share GHPC masked AND2 with valid/ready on data, randomness and output.
// PIPE_IN=1 adds an input register stage in front of the masking core (latency 2).
module msk_and_ghpcll_pipe #(
  parameter int d       = 2,
  parameter int W       = 8,
  parameter int PIPE_IN = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*W-1:0] ina,
  input  logic [2*W-1:0] inb,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] rnd,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  output logic [2*W-1:0] out,
  output logic           out_valid,
  input  logic           out_ready
);

  if (d != 2) begin : g_bad_d
    $error("msk_and_ghpcll_pipe: only d=2 shares is supported");
  end
  if (W < 1 || W > 64) begin : g_bad_w
    $error("msk_and_ghpcll_pipe: W must be in 1..64");
  end

  logic           accept;
  logic           core_load;
  logic [2*W-1:0] core_a;
  logic [2*W-1:0] core_b;
  logic [4*W-1:0] core_r;
  logic           out_valid_q;
  logic           out_valid_d;

  // Gating with rst_n keeps randomness from being reported as consumed while in reset.
  assign accept    = in_valid & rnd_valid & in_ready & rst_n;
  assign rnd_ready = accept;

  if (PIPE_IN == 0) begin : g_direct
    assign in_ready  = ~out_valid_q | out_ready;
    assign core_load = accept;
    assign core_a    = ina;
    assign core_b    = inb;
    assign core_r    = rnd;
  end else begin : g_stage0
    logic [2*W-1:0] a0_q;
    logic [2*W-1:0] b0_q;
    logic [4*W-1:0] r0_q;
    logic           v0_q;
    logic           v0_d;

    assign core_load = v0_q & (~out_valid_q | out_ready);
    assign in_ready  = ~v0_q | core_load;

    always_comb begin
      v0_d = v0_q;
      if (accept) begin
        v0_d = 1'b1;
      end else if (core_load) begin
        v0_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a0_q <= '0;
        b0_q <= '0;
        r0_q <= '0;
        v0_q <= 1'b0;
      end else begin
        v0_q <= v0_d;
        if (accept) begin
          a0_q <= ina;
          b0_q <= inb;
          r0_q <= rnd;
        end
      end
    end

    assign core_a = a0_q;
    assign core_b = b0_q;
    assign core_r = r0_q;
  end

  logic [4*W-1:0] fx;
  logic [4*W-1:0] sel_d;
  logic [4*W-1:0] r_fx_d;
  logic [W-1:0]   r_sel_d;
  logic [4*W-1:0] sel_q;
  logic [4*W-1:0] r_fx_q;
  logic [W-1:0]   r_sel_q;

  // fx uses only share 0, sel only share 1; they meet only after the registers.
  always_comb begin
    fx      = '0;
    sel_d   = '0;
    r_sel_d = '0;
    for (int i = 0; i < W; i++) begin
      fx[4*i+3]    = ~core_a[i] & ~core_b[i];
      fx[4*i+2]    = ~core_a[i] &  core_b[i];
      fx[4*i+1]    =  core_a[i] & ~core_b[i];
      fx[4*i+0]    =  core_a[i] &  core_b[i];
      sel_d[4*i+3] =  core_a[W+i] &  core_b[W+i];
      sel_d[4*i+2] =  core_a[W+i] & ~core_b[W+i];
      sel_d[4*i+1] = ~core_a[W+i] &  core_b[W+i];
      sel_d[4*i+0] = ~core_a[W+i] & ~core_b[W+i];
      r_sel_d[i]   = ^(core_r[4*i +: 4] & sel_d[4*i +: 4]);
    end
  end

  assign r_fx_d = fx ^ core_r;

  always_comb begin
    out_valid_d = out_valid_q;
    if (core_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fx_q      <= '0;
      sel_q       <= '0;
      r_sel_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (core_load) begin
        r_fx_q  <= r_fx_d;
        sel_q   <= sel_d;
        r_sel_q <= r_sel_d;
      end
    end
  end

  // Output is forced to the all-zero sharing whenever nothing valid is presented.
  always_comb begin
    out = '0;
    if (out_valid_q) begin
      for (int i = 0; i < W; i++) begin
        out[W+i] = ^(r_fx_q[4*i +: 4] & sel_q[4*i +: 4]);
        out[i]   = r_sel_q[i];
      end
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_msk_and_ghpcll_pipe.sv
// Bench for msk_and_ghpcll_pipe: one instance per PIPE_IN value, scoreboard of expected
// unmasked results and share-0 values, directed stall/backpressure/reset steps.
module tb_msk_and_ghpcll_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] unm;
    logic [W-1:0] sh0;
    int           cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*W-1:0] ina       [2];
  logic [2*W-1:0] inb       [2];
  logic           in_valid  [2];
  logic           in_ready  [2];
  logic [4*W-1:0] rnd       [2];
  logic           rnd_valid [2];
  logic           rnd_ready [2];
  logic [2*W-1:0] out       [2];
  logic           out_valid [2];
  logic           out_ready [2];

  exp_t           sbq [2][$];
  int             pushCnt [2];
  int             popCnt  [2];
  int             dropCnt [2];
  bit             acc     [2];
  logic [2*W-1:0] snap    [2];
  bit             chkLat;
  int             cyc;
  int             asserts;
  int             fails;
  int             base    [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    msk_and_ghpcll_pipe #(.d(2), .W(W), .PIPE_IN(g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ina      (ina[g]),
      .inb      (inb[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .rnd      (rnd[g]),
      .rnd_valid(rnd_valid[g]),
      .rnd_ready(rnd_ready[g]),
      .out      (out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g])
    );
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] expUnm(logic [2*W-1:0] a, logic [2*W-1:0] b);
    return (a[W-1:0] ^ a[2*W-1:W]) & (b[W-1:0] ^ b[2*W-1:W]);
  endfunction

  // Share 0 carries the random bit chosen by the share-1 pair {a1,b1} of each lane.
  function automatic logic [W-1:0] expSh0(logic [2*W-1:0] a, logic [2*W-1:0] b,
                                          logic [4*W-1:0] r);
    logic [W-1:0] s;
    int           idx;
    s = '0;
    for (int i = 0; i < W; i++) begin
      idx  = 4*i + 2*int'(a[W+i]) + int'(b[W+i]);
      s[i] = r[idx];
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input int k,
                             input logic [63:0] observed, input logic [63:0] expected);
    asserts++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, k, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                               input logic [4*W-1:0] r, input logic iv, input logic rv);
    ina[k]       = a;
    inb[k]       = b;
    rnd[k]       = r;
    in_valid[k]  = iv;
    rnd_valid[k] = rv;
  endtask

  task automatic randData(input int k, input logic iv, input logic rv);
    applyStimulus(k, 16'($urandom), 16'($urandom), $urandom, iv, rv);
  endtask

  // Scoreboard: pops/compares on output handshake, pushes model results on input accept.
  task automatic sampleNeg();
    exp_t e;
    logic accNow;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (!rst_n) begin
        dropCnt[k] += sbq[k].size();
        sbq[k].delete();
        continue;
      end
      if (out_valid[k] && out_ready[k]) begin
        checkOutput("sb_has_entry", k, 64'(sbq[k].size() != 0), 64'd1);
        if (sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          popCnt[k]++;
          checkOutput("unmasked", k, 64'(out[k][W-1:0] ^ out[k][2*W-1:W]), 64'(e.unm));
          checkOutput("share0", k, 64'(out[k][W-1:0]), 64'(e.sh0));
          if (chkLat) checkOutput("latency", k, 64'(cyc - e.cyc), 64'(1 + k));
        end
      end
      accNow = in_valid[k] & rnd_valid[k] & in_ready[k];
      checkOutput("rnd_ready", k, 64'(rnd_ready[k]), 64'(accNow));
      if (accNow) begin
        e.unm = expUnm(ina[k], inb[k]);
        e.sh0 = expSh0(ina[k], inb[k], rnd[k]);
        e.cyc = cyc;
        sbq[k].push_back(e);
        pushCnt[k]++;
        acc[k] = 1'b1;
      end
    end
  endtask

  task automatic cycleEnd();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic streamRefresh();
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) randData(k, 1'b1, 1'b1);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      rnd_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    for (int n = 0; n < 20 && !done; n++) begin
      sampleNeg();
      cycleEnd();
      done = (sbq[0].size() == 0) && (sbq[1].size() == 0) && !out_valid[0] && !out_valid[1];
    end
    checkOutput("drain_done", 0, 64'(done), 64'd1);
  endtask

  initial begin
    asserts = 0;
    fails   = 0;
    cyc     = 0;
    chkLat  = 1'b1;
    rst_n   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k, '0, '0, '0, 1'b0, 1'b0);
      out_ready[k] = 1'b1;
      pushCnt[k] = 0;
      popCnt[k]  = 0;
      dropCnt[k] = 0;
      acc[k]     = 1'b0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_in_ready", k, 64'(in_ready[k]), 64'd1);
      checkOutput("reset_out_valid", k, 64'(out_valid[k]), 64'd0);
      checkOutput("reset_out", k, 64'(out[k]), 64'd0);
      checkOutput("reset_rnd_ready", k, 64'(rnd_ready[k]), 64'd0);
    end
    rst_n = 1'b1;
    cycleEnd();

    $display("[TB] all 16 share combinations on lane 0, rnd=4'hA");
    for (int idx = 0; idx < 16; idx++) begin
      for (int k = 0; k < 2; k++) begin
        randData(k, 1'b1, 1'b1);
        ina[k][0]    = idx[3];
        ina[k][W]    = idx[2];
        inb[k][0]    = idx[1];
        inb[k][W]    = idx[0];
        rnd[k][3:0]  = 4'hA;
      end
      sampleNeg();
      for (int k = 0; k < 2; k++) begin
        if (idx >= 1 + k) checkOutput("combo_out_valid", k, 64'(out_valid[k]), 64'd1);
      end
      cycleEnd();
    end
    drain();

    $display("[TB] 1000 random beats, continuous ready");
    for (int k = 0; k < 2; k++) begin
      randData(k, 1'b1, 1'b1);
      base[k] = popCnt[k];
    end
    for (int n = 0; n < 1000; n++) begin
      sampleNeg();
      for (int k = 0; k < 2; k++) begin
        checkOutput("stream_in_ready", k, 64'(in_ready[k]), 64'd1);
        if (n >= 1 + k) checkOutput("stream_out_valid", k, 64'(out_valid[k]), 64'd1);
      end
      cycleEnd();
      streamRefresh();
    end
    drain();
    for (int k = 0; k < 2; k++) begin
      checkOutput("stream_beats", k, 64'(popCnt[k] - base[k]), 64'd1000);
    end

    $display("[TB] randomness stall");
    for (int k = 0; k < 2; k++) begin
      randData(k, 1'b1, 1'b0);
      base[k] = pushCnt[k];
    end
    repeat (5) begin
      sampleNeg();
      for (int k = 0; k < 2; k++) begin
        checkOutput("stall_out_valid", k, 64'(out_valid[k]), 64'd0);
        checkOutput("stall_out", k, 64'(out[k]), 64'd0);
      end
      cycleEnd();
    end
    for (int k = 0; k < 2; k++) rnd_valid[k] = 1'b1;
    sampleNeg();
    cycleEnd();
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      rnd_valid[k] = 1'b0;
    end
    sampleNeg();
    for (int k = 0; k < 2; k++) begin
      checkOutput("stall_one_accept", k, 64'(pushCnt[k] - base[k]), 64'd1);
    end
    cycleEnd();
    drain();

    $display("[TB] output backpressure");
    chkLat = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_ready[k] = 1'b0;
      randData(k, 1'b1, 1'b1);
    end
    for (int c = 1; c <= 4; c++) begin
      sampleNeg();
      cycleEnd();
      streamRefresh();
      for (int k = 0; k < 2; k++) begin
        checkOutput("bp_in_ready", k, 64'(in_ready[k]), (c >= 1 + k) ? 64'd0 : 64'd1);
        if (c >= 1 + k) begin
          checkOutput("bp_out_valid", k, 64'(out_valid[k]), 64'd1);
          if (c == 1 + k) snap[k] = out[k];
          else checkOutput("bp_out_stable", k, 64'(out[k]), 64'(snap[k]));
        end
      end
    end
    for (int k = 0; k < 2; k++) out_ready[k] = 1'b1;
    repeat (6) begin
      sampleNeg();
      cycleEnd();
      streamRefresh();
    end
    drain();
    chkLat = 1'b1;

    $display("[TB] asynchronous reset mid-stream");
    for (int k = 0; k < 2; k++) randData(k, 1'b1, 1'b1);
    repeat (5) begin
      sampleNeg();
      cycleEnd();
      streamRefresh();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("arst_out_valid", k, 64'(out_valid[k]), 64'd0);
      checkOutput("arst_out", k, 64'(out[k]), 64'd0);
      checkOutput("arst_in_ready", k, 64'(in_ready[k]), 64'd1);
      checkOutput("arst_rnd_ready", k, 64'(rnd_ready[k]), 64'd0);
    end
    sampleNeg();
    cycleEnd();
    #2;
    rst_n = 1'b1;
    sampleNeg();
    cycleEnd();
    for (int k = 0; k < 2; k++) begin
      checkOutput("post_rst_out_valid", k, 64'(out_valid[k]), (k == 0) ? 64'd1 : 64'd0);
    end
    streamRefresh();
    repeat (3) begin
      sampleNeg();
      cycleEnd();
      streamRefresh();
    end
    drain();

    $display("[TB] a=b=8'hFF with share 0 = 8'h00, varying rnd");
    repeat (8) begin
      for (int k = 0; k < 2; k++) begin
        applyStimulus(k, {8'hFF, 8'h00}, {8'hFF, 8'h00}, $urandom, 1'b1, 1'b1);
      end
      sampleNeg();
      cycleEnd();
    end
    drain();

    for (int k = 0; k < 2; k++) begin
      checkOutput("no_loss_or_dup", k, 64'(popCnt[k] + dropCnt[k]), 64'(pushCnt[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/msk_and_ghpcll_pipe.md
Name: msk_and_ghpcll_pipe

Overview:
- W-lane, 2-share, low-latency GHPC masked AND2 datapath with valid/ready flow control on the data input, the randomness input and the output.
- Each lane computes a sharing of a&b from sharings of a and b, consuming 4 fresh random bits per lane per accepted beat.
- Optional input register stage (PIPE_IN) for timing closure.
- Sits between masked S-box/linear layers in masked cipher cores. Upstream holds data under backpressure instead of dropping it.

Parameters:
- d, 2: number of shares. Only 2 is legal; any other value must fail elaboration.
- W, 8: number of parallel AND lanes (1..64).
- PIPE_IN, 0: 0 gives latency 1; 1 inserts an input register stage, giving latency 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ina  input  2*W  sharing of a. Bits [W-1:0] are share 0 and bits [2W-1:W] are share 1, lane i at bit i of each share.
- inb  input  2*W  sharing of b, same layout as ina.
- in_valid  input  1  ina/inb valid.
- in_ready  output  1  beat accepted when in_valid & rnd_valid & in_ready.
- rnd  input  4*W  fresh randomness. Lane i uses rnd[4i+3:4i].
- rnd_valid  input  1  rnd valid.
- rnd_ready  output  1  rnd consumed this cycle. Equals the accept strobe.
- out  output  2*W  sharing of a&b, same layout as ina.
- out_valid  output  1  out holds a result.
- out_ready  input  1  downstream takes out when out_valid & out_ready.

Behaviour:
- Definitions: accept = in_valid & rnd_valid & in_ready. rnd_ready = in_valid & rnd_valid & in_ready.
- Randomness is never consumed without data, and data is never accepted without randomness.
- Per lane, share 0 terms: fx[3] = ~a0&~b0, fx[2] = ~a0&b0, fx[1] = a0&~b0, fx[0] = a0&b0.
- Per lane, share 1 select: sel[3] = a1&b1, sel[2] = a1&~b1, sel[1] = ~a1&b1, sel[0] = ~a1&~b1. sel is one-hot.
- Core registers, per lane, loaded on the accept strobe of the last stage:
  - r_fx <= fx ^ r
  - sel_d <= sel
  - r_sel <= XOR(r & sel)
- Outputs: out share 1 lane i = XOR(r_fx & sel_d); out share 0 lane i = r_sel.
- Correctness: out0 ^ out1 = (a0^a1)&(b0^b1) for every lane.
- Domain separation:
  - r_fx depends only on share 0 and rnd; sel_d depends only on share 1.
  - No combinational path mixes share 0 and share 1 before a register.
  - Only the output XOR-AND tree mixes domains, and only from registers.
- When no load occurs, all core registers hold their value; no re-randomisation occurs.
- PIPE_IN=0:
  - One stage. in_ready = ~out_valid | out_ready.
  - out_valid is set on accept and cleared on (out_valid & out_ready & ~accept).
  - Latency 1: result visible the cycle after accept. Throughput 1 beat/cycle under continuous ready.
- PIPE_IN=1:
  - Stage 0 registers ina, inb, rnd and v0 (its valid bit).
  - Stage 1 is the core above, fed from the stage 0 registers.
  - Stage 1 loads when v0 & (~out_valid | out_ready).
  - Stage 0 loads on accept. in_ready = ~v0 | stage-1-load.
  - Latency 2. Full throughput. No combinational path from out_ready to in_ready beyond this one term.
- Reset, asynchronous, any time including mid-stall:
  - All data registers go to 0; out_valid and v0 go to 0.
  - in_ready goes to 1 and rnd_ready goes to 0.
  - out reads 0 (a valid sharing of 0) while out_valid=0.
  - In-flight beats are discarded.
- Simultaneous pop and accept in a full stage: the new beat replaces the old one in the same edge and out_valid stays 1.
- rnd_valid=0 while in_valid=1: no accept, in_valid must be held by upstream, all state holds.
- out must remain stable while out_valid & ~out_ready.

Test Plan:
- W=8, PIPE_IN=0. Drive all 16 (a0,a1,b0,b1) combinations on lane 0 with rnd=4'hA and other lanes random. Required: out0^out1 == (a0^a1)&(b0^b1) one cycle after each accept, with out_valid=1.
- Random a/b/rnd, 1000 beats, out_ready=1, both PIPE_IN values. Required: every unmasked result equals a&b. Latency is exactly 1 or 2 cycles. One beat per cycle after fill.
- in_valid=1, rnd_valid=0 for 5 cycles, then 1. Required: rnd_ready=0 and out_valid unchanged during the stall. Exactly one accept when rnd_valid rises.
- out_ready=0 for 4 cycles with a continuous input stream. Required: out bits stable and in_ready=0 once full (PIPE_IN=0 after 1 beat, PIPE_IN=1 after 2). No beat lost or duplicated after release.
- Assert rst_n=0 mid-stream between clock edges. Required: out_valid=0, out=0 and in_ready=1 immediately. First post-reset accept yields the correct result.
- Fixed a=b=8'hFF with share 0 = 8'h00, varying rnd. Required: out share 0 equals the selected rnd bit per lane, and unmasked out = 8'hFF.
